// File: rtl/astar_pkg.sv
// Shared grid constants, enums and coordinate helpers for the A* backtrace unit.
// The grid is 10x10 with the search goal fixed at (END_ROW, END_COL).
package astar_pkg;

    localparam logic [3:0] GRID_ROWS = 4'd10;
    localparam logic [3:0] GRID_COLS = 4'd10;
    localparam logic [3:0] END_ROW   = 4'd0;
    localparam logic [3:0] END_COL   = 4'd9;
    localparam logic [6:0] MAX_PATH  = 7'd100;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        DOWN  = 2'b01,
        LEFT  = 2'b10,
        RIGHT = 2'b11
    } dir_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EMIT = 3'd1,
        READ = 3'd2,
        WAIT = 3'd3,
        DONE = 3'd4
    } bt_state_e;

    typedef struct packed {
        logic [3:0] row;
        logic [3:0] col;
    } coord_t;

    // row*10 + col without a multiplier
    function automatic logic [6:0] coord_addr(input coord_t c);
        logic [6:0] r;
        r = {3'b000, c.row};
        return (r << 3) + (r << 1) + {3'b000, c.col};
    endfunction

endpackage

// File: rtl/astar_coord_step.sv
// One grid step from (row, col) in direction dir, flagging moves that leave the grid.
module astar_coord_step
    import astar_pkg::*;
(
    input  logic [3:0] row_i,
    input  logic [3:0] col_i,
    input  logic [1:0] dir_i,
    output logic [3:0] nrow_o,
    output logic [3:0] ncol_o,
    output logic       oob_o
);

    always_comb begin
        nrow_o = row_i;
        ncol_o = col_i;
        oob_o  = 1'b0;
        case (dir_e'(dir_i))
            UP: begin
                oob_o  = (row_i == 4'd0);
                nrow_o = row_i - 4'd1;
            end
            DOWN: begin
                oob_o  = (row_i >= GRID_ROWS - 4'd1);
                nrow_o = row_i + 4'd1;
            end
            LEFT: begin
                oob_o  = (col_i == 4'd0);
                ncol_o = col_i - 4'd1;
            end
            RIGHT: begin
                oob_o  = (col_i >= GRID_COLS - 4'd1);
                ncol_o = col_i + 4'd1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/astar_backtrace.sv
// Walks the parent-direction memory from the goal back to the start cell,
// emitting one path cell per EMIT state and stopping on bad links or overlong paths.
module astar_backtrace
    import astar_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       backtrace_en,
    input  logic [3:0] start_row,
    input  logic [3:0] start_col,
    output logic       parent_rd_en,
    output logic [6:0] parent_addr,
    input  logic [2:0] parent_rd_data,
    output logic       path_wr_en,
    output logic [3:0] path_wr_row,
    output logic [3:0] path_wr_col,
    output logic [6:0] path_len,
    output logic       backtrace_done,
    output logic       bt_error
);

    bt_state_e  state_q, state_d;
    coord_t     cur_q, cur_d;
    coord_t     start_q, start_d;
    logic [6:0] len_q, len_d;
    logic       err_q, err_d;
    logic       en_q;
    logic       armed_q;
    logic       job_start;
    logic       wr_en, rd_en, done;
    logic [3:0] nrow, ncol;
    logic       oob;

    // armed_q blocks an en that is already high when reset is released
    assign job_start = backtrace_en && !en_q && armed_q;

    astar_coord_step u_step (
        .row_i  (cur_q.row),
        .col_i  (cur_q.col),
        .dir_i  (parent_rd_data[1:0]),
        .nrow_o (nrow),
        .ncol_o (ncol),
        .oob_o  (oob)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cur_q   <= '0;
            start_q <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            start_q <= start_d;
            len_q   <= len_d;
            err_q   <= err_d;
            en_q    <= backtrace_en;
            armed_q <= armed_q || !backtrace_en;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        start_d = start_q;
        len_d   = len_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (job_start) begin
                    state_d = EMIT;
                    cur_d   = '{row: END_ROW, col: END_COL};
                    start_d = '{row: start_row, col: start_col};
                    len_d   = '0;
                    err_d   = 1'b0;
                end
            end
            EMIT: begin
                wr_en   = 1'b1;
                len_d   = len_q + 7'd1;
                state_d = (cur_q == start_q) ? DONE : READ;
            end
            READ: begin
                rd_en   = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (!parent_rd_data[2] || oob || len_q == MAX_PATH) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cur_d   = '{row: nrow, col: ncol};
                    state_d = EMIT;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Losing en only changes where we go next; the current cycle's strobe still counts
        if (!backtrace_en && state_q inside {EMIT, READ, WAIT}) begin
            state_d = IDLE;
            err_d   = err_q;
        end
    end

    assign path_wr_en     = wr_en;
    assign path_wr_row    = wr_en ? cur_q.row : 4'd0;
    assign path_wr_col    = wr_en ? cur_q.col : 4'd0;
    assign parent_rd_en   = rd_en;
    assign parent_addr    = rd_en ? coord_addr(cur_q) : 7'd0;
    assign path_len       = len_q;
    assign bt_error       = err_q;
    assign backtrace_done = done;

endmodule
